// File: rtl/noc_packet_sink_pkg.sv
// Shared types and framing constants for the NoC packet sink.
package noc_packet_sink_pkg;

    // Position of each framing flit within a packet.
    localparam int unsigned HDR_FLIT_IDX  = 0;
    localparam int unsigned SIZE_FLIT_IDX = 1;

    // Parser states; the header and size states are encoded by their flit index.
    typedef enum logic [1:0] {
        S_HEADER  = 2'(HDR_FLIT_IDX),
        S_SIZE    = 2'(SIZE_FLIT_IDX),
        S_PAYLOAD = 2'd2
    } sink_state_t;

endpackage

// File: rtl/noc_sink_fifo.sv
// Show-ahead flit FIFO: the head entry is presented combinationally.
module noc_sink_fifo #(
    parameter int unsigned FLIT_SIZE    = 32,
    parameter int unsigned BUFFER_DEPTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic [FLIT_SIZE-1:0] data_i,
    input  logic                 pop_i,
    output logic [FLIT_SIZE-1:0] head_o,
    output logic                 full_o,
    output logic                 empty_o
);
    localparam int unsigned AW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;

    logic [FLIT_SIZE-1:0] mem_q [BUFFER_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic                 pop_en, push_en;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(BUFFER_DEPTH));
    assign head_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy update; a push at full is legal only with a pop.
    always_comb begin
        pop_en   = pop_i && !empty_o;
        push_en  = push_i && (!full_o || pop_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_en && !pop_en) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_en && !push_en) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/noc_packet_sink.sv
// Credit-based flit sink: buffers network flits and parses header/size/payload framing.
module noc_packet_sink
    import noc_packet_sink_pkg::*;
#(
    parameter int unsigned FLIT_SIZE    = 32,
    parameter int unsigned BUFFER_DEPTH = 8,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic                 credit_o,
    input  logic [FLIT_SIZE-1:0] data_i,
    output logic                 hdr_valid_o,
    output logic [FLIT_SIZE-1:0] hdr_o,
    output logic [FLIT_SIZE-1:0] size_o,
    output logic                 pl_valid_o,
    input  logic                 pl_ready_i,
    output logic [FLIT_SIZE-1:0] pl_data_o,
    output logic                 pl_last_o,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] pkt_count_o,
    output logic [CNT_WIDTH-1:0] flit_count_o
);
    sink_state_t          state_q, state_d;
    logic [FLIT_SIZE-1:0] hdr_q, hdr_d;
    logic [FLIT_SIZE-1:0] size_q, size_d;
    logic [FLIT_SIZE-1:0] remaining_q, remaining_d;
    logic                 hdr_valid_q, hdr_valid_d;
    logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
    logic [CNT_WIDTH-1:0] flit_count_q, flit_count_d;

    logic                 fifo_full, fifo_empty, fifo_pop, accept;
    logic [FLIT_SIZE-1:0] fifo_head;

    // Credit is withheld during reset so nothing is lost across it.
    assign credit_o = !fifo_full && !rst_i;
    assign accept   = rx_i && credit_o;

    noc_sink_fifo #(
        .FLIT_SIZE   (FLIT_SIZE),
        .BUFFER_DEPTH(BUFFER_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (accept),
        .data_i (data_i),
        .pop_i  (fifo_pop),
        .head_o (fifo_head),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign pl_valid_o   = (state_q == S_PAYLOAD) && !fifo_empty;
    assign pl_data_o    = fifo_head;
    assign pl_last_o    = pl_valid_o && (remaining_q == FLIT_SIZE'(1));
    assign busy_o       = (state_q != S_HEADER) || !fifo_empty;
    assign hdr_valid_o  = hdr_valid_q;
    assign hdr_o        = hdr_q;
    assign size_o       = size_q;
    assign pkt_count_o  = pkt_count_q;
    assign flit_count_o = flit_count_q;

    // Framing parser: header and size pop unconditionally, payload waits for the consumer.
    always_comb begin
        state_d      = state_q;
        hdr_d        = hdr_q;
        size_d       = size_q;
        remaining_d  = remaining_q;
        pkt_count_d  = pkt_count_q;
        hdr_valid_d  = 1'b0;
        fifo_pop     = 1'b0;
        flit_count_d = accept ? flit_count_q + CNT_WIDTH'(1) : flit_count_q;
        unique case (state_q)
            S_HEADER: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    hdr_d    = fifo_head;
                    state_d  = S_SIZE;
                end
            end
            S_SIZE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    size_d      = fifo_head;
                    hdr_valid_d = 1'b1;
                    if (fifo_head == '0) begin
                        pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
                        state_d     = S_HEADER;
                    end else begin
                        remaining_d = fifo_head;
                        state_d     = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (pl_valid_o && pl_ready_i) begin
                    fifo_pop    = 1'b1;
                    remaining_d = remaining_q - FLIT_SIZE'(1);
                    if (remaining_q == FLIT_SIZE'(1)) begin
                        pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
                        state_d     = S_HEADER;
                    end
                end
            end
            default: state_d = S_HEADER;
        endcase
    end

    // Parser and counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_HEADER;
            hdr_q        <= '0;
            size_q       <= '0;
            remaining_q  <= '0;
            hdr_valid_q  <= 1'b0;
            pkt_count_q  <= '0;
            flit_count_q <= '0;
        end else begin
            state_q      <= state_d;
            hdr_q        <= hdr_d;
            size_q       <= size_d;
            remaining_q  <= remaining_d;
            hdr_valid_q  <= hdr_valid_d;
            pkt_count_q  <= pkt_count_d;
            flit_count_q <= flit_count_d;
        end
    end

endmodule
